router_rr_out_arbiter: RTL and testbench

Round-robin scheduler that shares one router output port between num_ntrfs input queues.
Each input presents a head packet with a pending flag (FWFT FIFO style).
The block selects one pending input per cycle and pops it into a single-entry output register.
The output register drives a valid/ready link toward the output terminal.
It sits between the per-interface input FIFOs (pndng/pop/data_out) and an output interface of the mesh router.

---
 rtl/router_rr_out_arbiter_if.sv | 28 ++
 rtl/router_rr_out_arbiter.sv | 72 +++++++
 tb/tb_router_rr_out_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/router_rr_out_arbiter_if.sv
// Link bundle between the per-interface input FIFOs, the round-robin output arbiter
// and the downstream output terminal.
interface router_rr_out_arbiter_if #(
    parameter int pck_sz    = 40,
    parameter int num_ntrfs = 4,
    parameter int cnt_w     = 16
);
    localparam int src_w = (num_ntrfs > 1) ? $clog2(num_ntrfs) : 1;

    logic              pndng_in [num_ntrfs-1:0];
    logic [pck_sz-1:0] data_in  [num_ntrfs-1:0];
    logic              pop      [num_ntrfs-1:0];
    logic              out_valid;
    logic [pck_sz-1:0] out_data;
    logic [src_w-1:0]  out_src;
    logic              out_ready;
    logic [cnt_w-1:0]  pkt_cnt;

    // master: the arbiter; slave: the FIFOs plus output terminal around it
    modport master (
        input  pndng_in, data_in, out_ready,
        output pop, out_valid, out_data, out_src, pkt_cnt
    );
    modport slave (
        output pndng_in, data_in, out_ready,
        input  pop, out_valid, out_data, out_src, pkt_cnt
    );
endinterface

// File: rtl/router_rr_out_arbiter.sv
// Round-robin scheduler sharing one router output port between num_ntrfs FWFT input
// queues, buffering the granted head packet in a single-entry valid/ready register.
module router_rr_out_arbiter #(
    parameter int pck_sz    = 40,
    parameter int num_ntrfs = 4,
    parameter int cnt_w     = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    router_rr_out_arbiter_if.master bus
);
    localparam int src_w = (num_ntrfs > 1) ? $clog2(num_ntrfs) : 1;

    logic [src_w-1:0]  rr_ptr;
    logic              valid_q;
    logic [pck_sz-1:0] data_q;
    logic [src_w-1:0]  src_q;
    logic [cnt_w-1:0]  cnt_q;

    logic [src_w-1:0]  win;
    logic              found;
    logic              can_load;
    logic              grant;

    // Scan from the slot after the last winner; the sum never exceeds 2*num_ntrfs-1,
    // so a single conditional subtract wraps it back into range.
    always_comb begin
        logic [src_w:0] cand;
        cand  = '0;
        win   = '0;
        found = 1'b0;
        for (int k = 1; k <= num_ntrfs; k++) begin
            cand = {1'b0, rr_ptr} + (src_w+1)'(k);
            if (cand >= (src_w+1)'(num_ntrfs))
                cand = cand - (src_w+1)'(num_ntrfs);
            if (!found && bus.pndng_in[cand[src_w-1:0]]) begin
                found = 1'b1;
                win   = cand[src_w-1:0];
            end
        end
    end

    assign can_load = !valid_q || bus.out_ready;
    assign grant    = can_load && found && !reset;

    for (genvar gi = 0; gi < num_ntrfs; gi++) begin : g_pop
        assign bus.pop[gi] = grant && (win == src_w'(gi));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            src_q   <= '0;
            cnt_q   <= '0;
            rr_ptr  <= src_w'(num_ntrfs - 1);
        end else if (grant) begin
            valid_q <= 1'b1;
            data_q  <= bus.data_in[win];
            src_q   <= win;
            cnt_q   <= cnt_q + cnt_w'(1);
            rr_ptr  <= win;
        end else if (valid_q && bus.out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;
    assign bus.out_src   = src_q;
    assign bus.pkt_cnt   = cnt_q;
endmodule

// File: tb/tb_router_rr_out_arbiter.sv
// Self-checking bench for router_rr_out_arbiter: directed scenarios plus a randomized
// run, all compared against a cycle-level reference model of the arbitration rules.
module tb_router_rr_out_arbiter;
    localparam int PCK = 40;
    localparam int N   = 4;
    localparam int CW  = 4;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    router_rr_out_arbiter_if #(.pck_sz(PCK), .num_ntrfs(N), .cnt_w(CW)) bus ();
    router_rr_out_arbiter #(.pck_sz(PCK), .num_ntrfs(N), .cnt_w(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [N-1:0] pop_v;
    logic [N-1:0] req_v;
    always_comb begin
        pop_v = '0;
        req_v = '0;
        for (int i = 0; i < N; i++) begin
            pop_v[i] = bus.pop[i];
            req_v[i] = bus.pndng_in[i];
        end
    end

    // Reference model state: what the output register should hold and whose turn it is
    bit             m_valid;
    logic [PCK-1:0] m_data;
    int             m_src;
    int             m_ptr;
    int             m_cnt;

    function automatic int exp_win();
        if (reset) return -1;
        if (m_valid && !bus.out_ready) return -1;
        for (int k = 1; k <= N; k++) begin
            int j;
            j = (m_ptr + k) % N;
            if (bus.pndng_in[j]) return j;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_pop();
        int w;
        w = exp_win();
        return (w < 0) ? '0 : N'(1 << w);
    endfunction

    // Advance one clock, updating the model from inputs sampled just before the edge
    task automatic cycle();
        int             w;
        logic [PCK-1:0] d;
        bit             rs;
        bit             rdy;
        w   = exp_win();
        rs  = reset;
        rdy = bus.out_ready;
        d   = '0;
        if (w >= 0) d = bus.data_in[w];
        @(posedge clk);
        if (rs) begin
            m_valid = 0; m_data = '0; m_src = 0; m_cnt = 0; m_ptr = N - 1;
        end else if (w >= 0) begin
            m_valid = 1; m_data = d; m_src = w; m_ptr = w;
            m_cnt = (m_cnt + 1) % (1 << CW);
        end else if (m_valid && rdy) begin
            m_valid = 0;
        end
        #1;
    endtask

    task automatic set_req(input logic [N-1:0] r);
        for (int i = 0; i < N; i++) bus.pndng_in[i] = r[i];
    endtask

    task automatic rand_data();
        logic [63:0] r;
        for (int i = 0; i < N; i++) begin
            r = {$urandom(), $urandom()};
            bus.data_in[i] = r[PCK-1:0];
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_req('0);
        @(negedge clk);
        cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.out_ready = 1'b1;
        set_req('1);
        rand_data();
        repeat (2) begin
            @(negedge clk);
            n_cmp++;
            if (pop_v !== '0) begin n_err++; $display("FAIL reset_pop: pop=%b expected 0000", pop_v); end
            cycle();
        end
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", bus.out_valid); end
        n_cmp++;
        if (bus.pkt_cnt !== '0) begin n_err++; $display("FAIL reset_cnt: got %0d expected 0", bus.pkt_cnt); end
        n_cmp++;
        if (bus.out_data !== '0 || bus.out_src !== '0) begin
            n_err++; $display("FAIL reset_data: data=%h src=%0d expected 0/0", bus.out_data, bus.out_src);
        end
        n_cmp++;
        if (pop_v !== 4'b0001) begin n_err++; $display("FAIL first_grant: pop=%b expected 0001", pop_v); end
        cycle();
        set_req('0);
        cycle();
    endtask

    task automatic test_single();
        do_reset();
        bus.out_ready = 1'b1;
        set_req(4'b0100);
        bus.data_in[2] = 40'hAA;
        @(negedge clk);
        n_cmp++;
        if (pop_v !== 4'b0100) begin n_err++; $display("FAIL single_pop: pop=%b expected 0100", pop_v); end
        cycle();
        set_req('0);
        @(negedge clk);
        n_cmp++;
        if (pop_v !== '0) begin n_err++; $display("FAIL single_pop_once: pop=%b expected 0000", pop_v); end
        n_cmp++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 40'hAA || bus.out_src !== 2'd2) begin
            n_err++; $display("FAIL single_out: valid=%b data=%h src=%0d expected 1/aa/2",
                              bus.out_valid, bus.out_data, bus.out_src);
        end
        n_cmp++;
        if (bus.pkt_cnt !== 4'd1) begin n_err++; $display("FAIL single_cnt: got %0d expected 1", bus.pkt_cnt); end
        cycle();
    endtask

    task automatic test_contention();
        do_reset();
        bus.out_ready = 1'b1;
        set_req('1);
        for (int i = 0; i < 8; i++) begin
            rand_data();
            @(negedge clk);
            n_cmp++;
            if (pop_v !== N'(1 << (i % N))) begin
                n_err++; $display("FAIL contention_order[%0d]: pop=%b expected %b", i, pop_v, N'(1 << (i % N)));
            end
            n_cmp++;
            if (bus.pkt_cnt !== CW'(i)) begin
                n_err++; $display("FAIL contention_cnt[%0d]: got %0d expected %0d", i, bus.pkt_cnt, i);
            end
            n_cmp++;
            if (bus.out_data !== m_data) begin
                n_err++; $display("FAIL contention_data[%0d]: got %h expected %h", i, bus.out_data, m_data);
            end
            cycle();
        end
        set_req('0);
        cycle();
    endtask

    task automatic test_backpressure();
        logic [PCK-1:0] held;
        logic [63:0]    r;
        do_reset();
        bus.out_ready = 1'b1;
        set_req(4'b0010);
        rand_data();
        held = bus.data_in[1];
        @(negedge clk);
        cycle();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rand_data();
            set_req(N'($urandom()) | 4'b0010);
            @(negedge clk);
            n_cmp++;
            if (pop_v !== '0) begin n_err++; $display("FAIL stall_pop[%0d]: pop=%b expected 0000", i, pop_v); end
            n_cmp++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== held || bus.out_src !== 2'd1) begin
                n_err++; $display("FAIL stall_hold[%0d]: valid=%b data=%h src=%0d expected 1/%h/1",
                                  i, bus.out_valid, bus.out_data, bus.out_src, held);
            end
            cycle();
        end
        bus.out_ready = 1'b1;
        set_req(4'b0010);
        r = {$urandom(), $urandom()};
        bus.data_in[1] = r[PCK-1:0];
        @(negedge clk);
        n_cmp++;
        if (pop_v !== 4'b0010) begin n_err++; $display("FAIL release_pop: pop=%b expected 0010", pop_v); end
        cycle();
        set_req('0);
        @(negedge clk);
        n_cmp++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== r[PCK-1:0] || bus.pkt_cnt !== 4'd2) begin
            n_err++; $display("FAIL release_out: valid=%b data=%h cnt=%0d expected 1/%h/2",
                              bus.out_valid, bus.out_data, bus.pkt_cnt, r[PCK-1:0]);
        end
        cycle();
    endtask

    task automatic test_fair_skip();
        do_reset();
        bus.out_ready = 1'b1;
        set_req(4'b0010);
        @(negedge clk);
        cycle();
        set_req(4'b1001);
        @(negedge clk);
        n_cmp++;
        if (pop_v !== 4'b1000) begin n_err++; $display("FAIL skip_first: pop=%b expected 1000", pop_v); end
        cycle();
        @(negedge clk);
        n_cmp++;
        if (pop_v !== 4'b0001) begin n_err++; $display("FAIL skip_wrap: pop=%b expected 0001", pop_v); end
        cycle();
        set_req('0);
        repeat (2) begin
            @(negedge clk);
            n_cmp++;
            if (pop_v !== '0) begin n_err++; $display("FAIL idle_pop: pop=%b expected 0000", pop_v); end
            cycle();
        end
        set_req('1);
        @(negedge clk);
        n_cmp++;
        if (pop_v !== 4'b0010) begin n_err++; $display("FAIL idle_keeps_ptr: pop=%b expected 0010", pop_v); end
        cycle();
        set_req('0);
        cycle();
    endtask

    task automatic test_wrap_reset();
        do_reset();
        bus.out_ready = 1'b1;
        set_req('1);
        repeat (17) begin
            rand_data();
            @(negedge clk);
            cycle();
        end
        bus.out_ready = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.pkt_cnt !== 4'd1 || bus.out_valid !== 1'b1) begin
            n_err++; $display("FAIL cnt_wrap: cnt=%0d valid=%b expected 1/1", bus.pkt_cnt, bus.out_valid);
        end
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (pop_v !== '0) begin n_err++; $display("FAIL reset_stall_pop: pop=%b expected 0000", pop_v); end
        cycle();
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.pkt_cnt !== '0) begin
            n_err++; $display("FAIL reset_stall_out: valid=%b cnt=%0d expected 0/0", bus.out_valid, bus.pkt_cnt);
        end
        n_cmp++;
        if (pop_v !== 4'b0001) begin n_err++; $display("FAIL reset_stall_grant: pop=%b expected 0001", pop_v); end
        cycle();
        set_req('0);
        bus.out_ready = 1'b1;
        cycle();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 39) == 0);
            bus.out_ready = ($urandom_range(0, 9) < 7);
            set_req(N'($urandom()));
            rand_data();
            @(negedge clk);
            n_cmp++;
            if (pop_v !== exp_pop()) begin
                n_err++; $display("FAIL rand_pop[%0d]: pop=%b expected %b", i, pop_v, exp_pop());
            end
            n_cmp++;
            if ((pop_v & ~req_v) !== '0) begin
                n_err++; $display("FAIL rand_pop_idle_queue[%0d]: pop=%b req=%b expected subset", i, pop_v, req_v);
            end
            n_cmp++;
            if (bus.out_valid !== m_valid || bus.out_data !== m_data ||
                bus.out_src !== 2'(m_src) || bus.pkt_cnt !== CW'(m_cnt)) begin
                n_err++; $display("FAIL rand_out[%0d]: v=%b d=%h s=%0d c=%0d expected %b/%h/%0d/%0d", i,
                                  bus.out_valid, bus.out_data, bus.out_src, bus.pkt_cnt,
                                  m_valid, m_data, m_src, m_cnt);
            end
            cycle();
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus.out_ready = 1'b0;
        set_req('0);
        for (int i = 0; i < N; i++) bus.data_in[i] = '0;
        m_valid = 0; m_data = '0; m_src = 0; m_ptr = N - 1; m_cnt = 0;
        #1;
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_fair_skip();
        test_wrap_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
